// File: rtl/adc_array_pkg.sv
// adc_array_pkg: FSM state type, conversion pulse width and parameter defaults
// shared by the ADC array collector and its sclk generator.
package adc_array_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        WAIT_BUSY,
        SHIFT,
        DRAIN
    } state_t;

    localparam int CNVST_PULSE      = 2;
    localparam int NUM_CH_DEF       = 4;
    localparam int SAMPLE_W_DEF     = 16;
    localparam int SCLK_HALF_DEF    = 2;
    localparam int BUSY_TIMEOUT_DEF = 64;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: sclk divider, idle low while disabled, with one-cycle
// strobes on the clk cycle where sclk rises or falls.
module adc_sclk_gen
    import adc_array_pkg::*;
#(
    parameter int SCLK_HALF = SCLK_HALF_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
    localparam logic [HW-1:0] LAST = HW'(SCLK_HALF - 1);

    logic [HW-1:0] cnt;
    logic          tick;

    assign tick = en && (cnt == LAST);
    assign rise = tick && !sclk;
    assign fall = tick && sclk;

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (tick) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + HW'(1);
        end
    end

endmodule

// File: rtl/adc_array_collector.sv
// adc_array_collector: drives a bank of serial ADCs in lockstep and streams
// their samples out in channel order. Parity output: ADC_STREAM_PARITY_EN.
module adc_array_collector
    import adc_array_pkg::*;
#(
    parameter int NUM_CH       = NUM_CH_DEF,
    parameter int SAMPLE_W     = SAMPLE_W_DEF,
    parameter int SCLK_HALF    = SCLK_HALF_DEF,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      cnvst_n,
    output logic                      cs_n,
    output logic                      sclk,
    input  logic [NUM_CH-1:0]         busy,
    input  logic [NUM_CH-1:0]         sdout,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SAMPLE_W-1:0]       out_data,
    output logic [ch_w(NUM_CH)-1:0]   out_ch,
    output logic                      out_parity,
    output logic                      frame_done,
    output logic                      overrun,
    output logic [NUM_CH-1:0]         adc_error,
    output logic                      any_error,
    input  logic                      clear_error
);

    localparam int CH_W   = ch_w(NUM_CH);
    localparam int CNT_W  = $clog2(BUSY_TIMEOUT + CNVST_PULSE + 1);
    localparam int RISE_W = $clog2(SAMPLE_W + 1);

    localparam logic [CNT_W-1:0]  CNV_LAST = CNT_W'(CNVST_PULSE - 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);
    localparam logic [RISE_W-1:0] RISE_N   = RISE_W'(SAMPLE_W);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [RISE_W-1:0]   rise_q;
    logic [NUM_CH-1:0]   to_mask_q;
    logic [SAMPLE_W-1:0] sreg [NUM_CH];

    logic            sclk_rise;
    logic            sclk_fall;
    logic            busy_any;
    logic            timeout;
    logic            accept;
    logic            load_en;
    logic [CH_W-1:0] load_ch;
    logic            last_acc;

    assign busy_any  = |busy;
    assign timeout   = (state_q == WAIT_BUSY) && busy_any && (cnt_q == TO_LAST);
    assign accept    = out_valid && out_ready;
    assign any_error = |adc_error;

    adc_sclk_gen #(
        .SCLK_HALF (SCLK_HALF)
    ) u_sclk (
        .clk   (clk),
        .reset (reset),
        .en    (state_q == SHIFT),
        .sclk  (sclk),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_en  = 1'b0;
        load_ch  = '0;
        last_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONVERT;
                end
            end
            CONVERT: begin
                if (cnt_q == CNV_LAST) begin
                    state_d = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!busy_any || cnt_q == TO_LAST) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // hold until sclk falls again so it leaves SHIFT low
                if (rise_q == RISE_N && sclk_fall) begin
                    state_d = DRAIN;
                    load_en = 1'b1;
                end
            end
            DRAIN: begin
                if (accept) begin
                    if (out_ch == CH_LAST) begin
                        state_d  = IDLE;
                        last_acc = 1'b1;
                    end else begin
                        load_en = 1'b1;
                        load_ch = out_ch + CH_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rise_q    <= '0;
            to_mask_q <= '0;
            cnvst_n   <= 1'b1;
            cs_n      <= 1'b1;
        end else begin
            cnvst_n <= (state_d != CONVERT);
            cs_n    <= (state_d != SHIFT);
            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (state_q == CONVERT || state_q == WAIT_BUSY) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (state_q != SHIFT) begin
                rise_q <= '0;
            end else if (sclk_rise) begin
                rise_q <= rise_q + RISE_W'(1);
            end
            if (state_q == IDLE && start) begin
                to_mask_q <= '0;
            end else if (state_q == WAIT_BUSY && state_d == SHIFT) begin
                to_mask_q <= timeout ? busy : '0;
            end
        end
    end

    // timed-out channels shift in zeros so their word reads back as 0
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (reset) begin
                sreg[c] <= '0;
            end else if (sclk_rise) begin
                sreg[c] <= (sreg[c] << 1)
                         | SAMPLE_W'(sdout[c] & ~to_mask_q[c]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overrun   <= 1'b0;
            adc_error <= '0;
        end else begin
            overrun   <= (overrun & ~clear_error)
                       | (start && state_q != IDLE);
            adc_error <= (adc_error & ~{NUM_CH{clear_error}})
                       | (timeout ? busy : '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_acc;
            if (load_en) begin
                out_valid <= 1'b1;
                out_ch    <= load_ch;
                out_data  <= sreg[load_ch];
            end else if (last_acc) begin
                out_valid <= 1'b0;
                out_ch    <= '0;
                out_data  <= '0;
            end
        end
    end

`ifdef ADC_STREAM_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_q <= 1'b0;
        end else if (load_en) begin
            parity_q <= ^sreg[load_ch];
        end else if (last_acc) begin
            parity_q <= 1'b0;
        end
    end

    assign out_parity = parity_q;
`else
    assign out_parity = 1'b0;
`endif

endmodule

// File: doc/adc_array_collector.md
ADC_ARRAY_COLLECTOR -- requirements
Module: adc_array_collector

Interface
REQ-001 Parameter NUM_CH, default 4, count of serial ADCs sharing one conversion/readout timing (1..16).
REQ-002 Parameter SAMPLE_W, default 16, bits per ADC sample, MSB first.
REQ-003 Parameter SCLK_HALF, default 2, clk cycles per sclk half-period (>=1).
REQ-004 Parameter BUSY_TIMEOUT, default 64, max clk cycles to wait for busy deassertion.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 start  in  1  single-cycle pulse requesting one conversion frame.
REQ-008 cnvst_n  out  1  conversion start to all ADCs, active low.
REQ-009 cs_n  out  1  chip select to all ADCs, active low during readout.
REQ-010 sclk  out  1  shared serial clock.
REQ-011 busy  in  NUM_CH  per-ADC conversion busy, active high.
REQ-012 sdout  in  NUM_CH  per-ADC serial data.
REQ-013 out_valid / out_ready  out / in  1 / 1  sample stream handshake.
REQ-014 out_data  out  SAMPLE_W  sample word; out_ch  out  $clog2(NUM_CH) (min 1)  channel index.
REQ-015 out_parity  out  1  even parity of out_data (see Configuration).
REQ-016 frame_done  out  1  one-cycle pulse after the last word of a frame is accepted.
REQ-017 overrun  out  1  sticky: start received while not IDLE.
REQ-018 adc_error  out  NUM_CH  sticky per-channel busy-timeout flags; any_error  out  1  OR of adc_error.
REQ-019 clear_error  in  1  single-cycle pulse clearing overrun and adc_error.

Function
REQ-020 FSM states IDLE, CONVERT, WAIT_BUSY, SHIFT, DRAIN.
REQ-021 IDLE: start -> CONVERT next cycle; cnvst_n low exactly 2 cycles, then WAIT_BUSY.
REQ-022 WAIT_BUSY: advance to SHIFT when busy is all-zero, or when the counter reaches BUSY_TIMEOUT; channels still busy at timeout set adc_error bit; their captured data is zero.
REQ-023 SHIFT: cs_n low; sclk starts low, toggles every SCLK_HALF cycles for SAMPLE_W rising edges; each sdout bit captured into its channel's shift register on the clk cycle sclk rises; cs_n high and sclk low on exit.
REQ-024 DRAIN: present channels 0..NUM_CH-1 in order; word advances only on out_valid&&out_ready; out_data/out_ch stable while out_valid&&!out_ready.
REQ-025 Last-word accept -> frame_done pulse same cycle as the transition to IDLE; out_valid low in all other states.
REQ-026 start in any non-IDLE state ignored and sets overrun; frame continues unaffected.
REQ-027 clear_error coincident with a new error event: the set wins.
REQ-028 any_error is combinational OR of adc_error.

Reset
REQ-029 reset forces IDLE; cnvst_n=1, cs_n=1, sclk=0, out_valid=0, out_data=0, out_ch=0, out_parity=0, frame_done=0, overrun=0, adc_error=0; counters and shift registers cleared.
REQ-030 reset mid-frame aborts immediately; no partial word is emitted afterwards.

Configuration
REQ-031 Macro ADC_STREAM_PARITY_EN: defined -> out_parity = XOR of out_data while out_valid, registered with data; undefined -> out_parity tied 0, no parity logic.

Structure
REQ-032 Shared package adc_array_pkg holds FSM state enum, CNVST_PULSE=2 constant and parameter defaults.
REQ-033 One sub-module adc_sclk_gen: divider producing sclk and a one-cycle rise-strobe, enabled only in SHIFT.

Verification
REQ-034 NUM_CH=4, SAMPLE_W=16, stubs return 16'h1234,16'hABCD,16'h0000,16'hFFFF, busy 10 cycles, out_ready=1 -> four words in order ch0..3, frame_done once.
REQ-035 Same, out_ready low 5 cycles on ch1 -> ch1 word held stable, no loss or duplication.
REQ-036 busy[2] stuck high -> after 64 cycles adc_error=4'b0100, any_error=1, ch2 word=0; clear_error -> flags 0.
REQ-037 start pulsed during SHIFT -> overrun=1, current frame completes normally, no second frame.
REQ-038 reset asserted mid-SHIFT -> next cycle all outputs at reset values; new start yields a correct full frame.
REQ-039 With ADC_STREAM_PARITY_EN, word 16'h0007 -> out_parity=1; without it out_parity=0.
